// File: rtl/uart_seq_pkg.sv
// -----------------------------------------------------------------------------
// uart_seq_pkg
//   Shared definitions for the UART APB sequencer: UART register map,
//   STATUS bit positions, sequencer FSM states and APB transfer phases.
// -----------------------------------------------------------------------------
package uart_seq_pkg;

    // UART register map (byte addresses on the 5-bit APB bus)
    localparam logic [4:0] ADDR_TX     = 5'h00;
    localparam logic [4:0] ADDR_RX     = 5'h04;
    localparam logic [4:0] ADDR_CR1    = 5'h08;
    localparam logic [4:0] ADDR_CR2    = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CR3    = 5'h14;

    // STATUS register bit positions
    localparam int ST_TXRDY    = 0;
    localparam int ST_RXRDY    = 1;
    localparam int ST_PARITY   = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_FRAMING  = 4;

    typedef enum logic [2:0] {
        S_INIT_CR1,
        S_INIT_CR2,
        S_INIT_CR3,
        S_POLL,
        S_DECIDE,
        S_RD_RX,
        S_WR_TX,
        S_GAP
    } seq_state_e;

    // Each transfer state walks IDLE -> SETUP -> ACCESS; the IDLE cycle
    // guarantees the bus drops to zero between back-to-back transfers.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } apb_phase_e;

    function automatic logic is_xfer_state(seq_state_e s);
        return (s != S_DECIDE) && (s != S_GAP);
    endfunction

endpackage

// File: rtl/uart_apb_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_apb_sequencer_if
//   APB3 bus between the sequencer (master) and the UART (slave).
//   m_paddr/m_psel/m_penable/m_pwrite/m_pwdata : master -> slave
//   m_prdata/m_pready                           : slave  -> master
// -----------------------------------------------------------------------------
interface uart_apb_sequencer_if;

    logic [4:0] m_paddr;
    logic       m_psel;
    logic       m_penable;
    logic       m_pwrite;
    logic [7:0] m_pwdata;
    logic [7:0] m_prdata;
    logic       m_pready;

    modport master (
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        input  m_prdata, m_pready
    );

    modport slave (
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        output m_prdata, m_pready
    );

endinterface

// File: rtl/uart_seq_rr_arb.sv
// -----------------------------------------------------------------------------
// uart_seq_rr_arb
//   Two-way round-robin arbiter for the TX requesters.
//   PCLK, PRESETN : clock, asynchronous active-low reset
//   req[1:0]      : request vector
//   advance       : the current grant has been served; favour the other one
//   gnt           : index of the granted requester
//   gnt only moves with req or advance; the owner pins req to the winner while
//   a transfer is in flight so the grant cannot change under it.
// -----------------------------------------------------------------------------
module uart_seq_rr_arb (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt
);

    logic ptr_q;
    logic ptr_d;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt   = ptr_q;
        ptr_d = ptr_q;
        unique case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = ptr_q;
        endcase
        if (advance) begin
            ptr_d = ~gnt;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_apb_sequencer.sv
// -----------------------------------------------------------------------------
// uart_apb_sequencer
//   APB3 master owning the UART. Programs CR1/CR2/(CR3) after reset, then
//   polls STATUS and moves bytes between the UART, two TX requesters and one
//   RX sink.
//   PCLK, PRESETN          : clock, asynchronous active-low reset
//   apb (master modport)   : APB3 bus to the UART
//   tx_valid/tx_data0/1    : TX requesters; tx_ready pulses on acceptance
//   rx_valid/rx_data       : RX holding register; cleared by rx_ready
//   cfg_reload / cfg_done  : rerun init (taken at DECIDE) / init complete
//   err_flags / err_clr    : sticky {framing, overflow, parity} / clear
// -----------------------------------------------------------------------------
module uart_apb_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0,
    parameter bit          FRCTN_EN   = 1'b0,
    parameter logic [2:0]  BAUD_FRCTN = 3'd0,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic                        PCLK,
    input  logic                        PRESETN,
    uart_apb_sequencer_if.master        apb,
    input  logic [1:0]                  tx_valid,
    input  logic [7:0]                  tx_data0,
    input  logic [7:0]                  tx_data1,
    output logic [1:0]                  tx_ready,
    output logic                        rx_valid,
    output logic [7:0]                  rx_data,
    input  logic                        rx_ready,
    input  logic                        cfg_reload,
    output logic                        cfg_done,
    output logic [2:0]                  err_flags,
    input  logic                        err_clr
);

    localparam int GAP_W = 16;
    // GAP is entered with the count already at POLL_GAP-1 so it lasts exactly
    // POLL_GAP cycles; with POLL_GAP=0 DECIDE goes straight back to POLL.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

    seq_state_e       state_q,    state_d;
    apb_phase_e       phase_q,    phase_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic [7:0]       wdata_q,    wdata_d;
    logic             sel_q,      sel_d;
    logic [1:0]       status_q,   status_d;   // captured {RXRDY, TXRDY}
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             cfg_done_q, cfg_done_d;
    logic [2:0]       err_q,      err_d;
    logic             reload_q,   reload_d;

    logic       xfer_done;
    logic       in_tx;
    logic [1:0] arb_req;
    logic       arb_gnt;
    logic       arb_advance;

    assign xfer_done = (phase_q == PH_ACCESS) && apb.m_pready;
    assign in_tx     = (state_q == S_WR_TX) && (phase_q != PH_IDLE);
    // While a write is in flight the arbiter sees only the winner's request,
    // so a requester dropping valid cannot move the grant mid-transfer.
    assign arb_req   = in_tx ? (sel_q ? 2'b10 : 2'b01) : tx_valid;

    uart_seq_rr_arb u_arb (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .req     (arb_req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    // APB outputs decode straight from state/phase; reset forces both to
    // their idle encodings, so the bus drops the instant PRESETN falls.
    always_comb begin
        apb.m_psel    = 1'b0;
        apb.m_penable = 1'b0;
        apb.m_pwrite  = 1'b0;
        apb.m_paddr   = 5'h00;
        apb.m_pwdata  = 8'h00;
        if (is_xfer_state(state_q) && (phase_q != PH_IDLE)) begin
            apb.m_psel    = 1'b1;
            apb.m_penable = (phase_q == PH_ACCESS);
            case (state_q)
                S_INIT_CR1: begin
                    apb.m_paddr  = ADDR_CR1;
                    apb.m_pwrite = 1'b1;
                    apb.m_pwdata = BAUD_VALUE[7:0];
                end
                S_INIT_CR2: begin
                    apb.m_paddr  = ADDR_CR2;
                    apb.m_pwrite = 1'b1;
                    apb.m_pwdata = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
                end
                S_INIT_CR3: begin
                    apb.m_paddr  = ADDR_CR3;
                    apb.m_pwrite = 1'b1;
                    apb.m_pwdata = {5'b00000, BAUD_FRCTN};
                end
                S_POLL:  apb.m_paddr = ADDR_STATUS;
                S_RD_RX: apb.m_paddr = ADDR_RX;
                S_WR_TX: begin
                    apb.m_paddr  = ADDR_TX;
                    apb.m_pwrite = 1'b1;
                    apb.m_pwdata = wdata_q;
                end
                default: apb.m_psel = 1'b0;
            endcase
        end
    end

    // Next-state, datapath updates and handshake pulses
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        gap_d       = gap_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        status_d    = status_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        cfg_done_d  = cfg_done_q;
        err_d       = err_q;
        reload_d    = reload_q | cfg_reload;
        tx_ready    = 2'b00;
        arb_advance = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (is_xfer_state(state_q)) begin
            unique case (phase_q)
                PH_IDLE:   phase_d = PH_SETUP;
                PH_SETUP:  phase_d = PH_ACCESS;
                PH_ACCESS: if (apb.m_pready) phase_d = PH_IDLE;
                default:   phase_d = PH_IDLE;
            endcase
        end

        case (state_q)
            S_INIT_CR1: if (xfer_done) state_d = S_INIT_CR2;
            S_INIT_CR2: begin
                if (xfer_done) begin
                    if (FRCTN_EN) begin
                        state_d = S_INIT_CR3;
                    end else begin
                        state_d    = S_POLL;
                        cfg_done_d = 1'b1;
                    end
                end
            end
            S_INIT_CR3: begin
                if (xfer_done) begin
                    state_d    = S_POLL;
                    cfg_done_d = 1'b1;
                end
            end
            S_POLL: begin
                if (xfer_done) begin
                    status_d = {apb.m_prdata[ST_RXRDY], apb.m_prdata[ST_TXRDY]};
                    err_d    = err_q | {apb.m_prdata[ST_FRAMING],
                                        apb.m_prdata[ST_OVERFLOW],
                                        apb.m_prdata[ST_PARITY]};
                    state_d  = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (reload_q) begin
                    state_d    = S_INIT_CR1;
                    cfg_done_d = 1'b0;
                    reload_d   = cfg_reload;   // keep a pulse landing this cycle
                end else if (status_q[1] && (!rx_valid_q || rx_ready)) begin
                    state_d = S_RD_RX;
                end else if (status_q[0] && (|tx_valid)) begin
                    state_d = S_WR_TX;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            S_RD_RX: begin
                if (xfer_done) begin
                    rx_data_d  = apb.m_prdata;
                    rx_valid_d = 1'b1;
                    state_d    = S_POLL;
                end
            end
            S_WR_TX: begin
                if (phase_q == PH_IDLE) begin
                    sel_d   = arb_gnt;
                    wdata_d = arb_gnt ? tx_data1 : tx_data0;
                end
                if (xfer_done) begin
                    tx_ready[sel_q] = 1'b1;
                    arb_advance     = 1'b1;
                    state_d         = S_POLL;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_POLL;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_INIT_CR1;
        endcase

        // A clear outranks a same-cycle set from POLL.
        if (err_clr) begin
            err_d = 3'b000;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= S_INIT_CR1;
            phase_q    <= PH_IDLE;
            gap_q      <= '0;
            wdata_q    <= 8'h00;
            sel_q      <= 1'b0;
            status_q   <= 2'b00;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            cfg_done_q <= 1'b0;
            err_q      <= 3'b000;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            gap_q      <= gap_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            status_q   <= status_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
            reload_q   <= reload_d;
        end
    end

    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign cfg_done  = cfg_done_q;
    assign err_flags = err_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_sequencer
//   Directed bench for uart_apb_sequencer with a reactive UART APB slave model
//   that logs every completed transfer.
// -----------------------------------------------------------------------------
module tb_uart_apb_sequencer;
    import uart_seq_pkg::*;

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] data;
    } xfer_t;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic [1:0] tx_valid = 2'b00;
    logic [7:0] tx_data0 = 8'h00;
    logic [7:0] tx_data1 = 8'h00;
    logic [1:0] tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       cfg_reload = 1'b0;
    logic       cfg_done;
    logic [2:0] err_flags;
    logic       err_clr = 1'b0;

    logic [7:0] status_val = 8'h00;
    logic [7:0] rx_val = 8'h00;
    int         pready_wait = 0;
    int         wait_left = 0;
    xfer_t      log_q[$];
    xfer_t      slv_rec;
    int         tx_cnt0 = 0;
    int         tx_cnt1 = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 PCLK = ~PCLK;

    uart_apb_sequencer_if apb_if();

    uart_apb_sequencer #(
        .BAUD_VALUE (13'h123),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b0),
        .ODD_N_EVEN (1'b0),
        .FRCTN_EN   (1'b1),
        .BAUD_FRCTN (3'd5),
        .POLL_GAP   (4)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .apb        (apb_if),
        .tx_valid   (tx_valid),
        .tx_data0   (tx_data0),
        .tx_data1   (tx_data1),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .cfg_reload (cfg_reload),
        .cfg_done   (cfg_done),
        .err_flags  (err_flags),
        .err_clr    (err_clr)
    );

    // UART slave: answers on the falling edge, holds pready low for
    // pready_wait ACCESS cycles, logs each transfer as it completes.
    always @(negedge PCLK) begin
        if (apb_if.m_psel && apb_if.m_penable) begin
            if (wait_left > 0) begin
                apb_if.m_pready = 1'b0;
                wait_left = wait_left - 1;
            end else begin
                apb_if.m_pready = 1'b1;
                if (apb_if.m_paddr == ADDR_STATUS)  apb_if.m_prdata = status_val;
                else if (apb_if.m_paddr == ADDR_RX) apb_if.m_prdata = rx_val;
                else                                apb_if.m_prdata = 8'h00;
                slv_rec.addr = apb_if.m_paddr;
                slv_rec.wr   = apb_if.m_pwrite;
                slv_rec.data = apb_if.m_pwrite ? apb_if.m_pwdata : apb_if.m_prdata;
                log_q.push_back(slv_rec);
            end
        end else begin
            apb_if.m_pready = 1'b0;
            apb_if.m_prdata = 8'h00;
            wait_left = pready_wait;
        end
    end

    always @(negedge PCLK) begin
        #1;
        if (tx_ready[0]) tx_cnt0++;
        if (tx_ready[1]) tx_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge PCLK);
            #2;
        end
    endtask

    task automatic next_xfer(input string tag, output xfer_t rec);
        int   waited = 0;
        logic seen;
        while (log_q.size() == 0 && waited < 300) begin
            step(1);
            waited++;
        end
        seen = (log_q.size() != 0);
        if (!seen) begin
            check({tag, "_timeout"}, 32'(seen), 32'd1);
            rec.addr = 5'h1F;
            rec.wr   = 1'b0;
            rec.data = 8'h00;
        end else begin
            rec = log_q.pop_front();
        end
    endtask

    task automatic next_nonpoll(input string tag, output xfer_t rec);
        int tries = 0;
        next_xfer(tag, rec);
        while (rec.addr == ADDR_STATUS && tries < 40) begin
            next_xfer(tag, rec);
            tries++;
        end
    endtask

    // Expected init: CR1<-0x23, CR2<-0x09, CR3<-0x05, then cfg_done and a poll.
    task automatic expect_init(input string tag);
        xfer_t r;
        next_xfer(tag, r);
        check({tag, "_cr1"}, {r.wr, r.addr, r.data}, {1'b1, ADDR_CR1, 8'h23});
        next_xfer(tag, r);
        check({tag, "_cr2"}, {r.wr, r.addr, r.data}, {1'b1, ADDR_CR2, 8'h09});
        next_xfer(tag, r);
        check({tag, "_cr3"}, {r.wr, r.addr, r.data}, {1'b1, ADDR_CR3, 8'h05});
        check({tag, "_done_before_cr3_end"}, cfg_done, 1'b0);
        step(1);
        check({tag, "_cfg_done"}, cfg_done, 1'b1);
        next_xfer(tag, r);
        check({tag, "_first_poll"}, {r.wr, r.addr}, {1'b0, ADDR_STATUS});
    endtask

    initial begin
        xfer_t r;
        int    reads;
        int    polls;
        int    c0;
        int    found;

        // ---- T1: reset values and init sequence ----
        step(3);
        check("rst_psel",     apb_if.m_psel,    1'b0);
        check("rst_penable",  apb_if.m_penable, 1'b0);
        check("rst_paddr",    apb_if.m_paddr,   5'h00);
        check("rst_outs",     {tx_ready, rx_valid, cfg_done, err_flags}, 7'b0);
        PRESETN = 1'b1;
        expect_init("t1");

        // ---- T2: both requesters, alternating A5/5A ----
        tx_data0   = 8'hA5;
        tx_data1   = 8'h5A;
        tx_valid   = 2'b11;
        status_val = 8'h01;
        for (int i = 0; i < 4; i++) begin
            next_nonpoll("t2", r);
            check($sformatf("t2_wr%0d", i), {r.wr, r.addr, r.data},
                  {1'b1, ADDR_TX, (i % 2 == 0) ? 8'hA5 : 8'h5A});
            check($sformatf("t2_rdy0_%0d", i), tx_cnt0, (i + 2) / 2);
            check($sformatf("t2_rdy1_%0d", i), tx_cnt1, (i + 1) / 2);
        end
        tx_valid = 2'b00;

        // ---- T3: RX has priority over TX ----
        status_val = 8'h03;
        rx_val     = 8'h3C;
        log_q.delete();
        next_xfer("t3_poll0", r);
        tx_data0 = 8'h11;
        tx_valid = 2'b01;
        next_xfer("t3_rd", r);
        check("t3_rd", {r.wr, r.addr, r.data}, {1'b0, ADDR_RX, 8'h3C});
        step(1);
        check("t3_rx_valid", rx_valid, 1'b1);
        check("t3_rx_data",  rx_data,  8'h3C);
        next_xfer("t3_poll1", r);
        check("t3_poll_between", {r.wr, r.addr}, {1'b0, ADDR_STATUS});
        next_xfer("t3_wr", r);
        check("t3_wr", {r.wr, r.addr, r.data}, {1'b1, ADDR_TX, 8'h11});
        tx_valid = 2'b00;
        check("t3_rdy0", tx_cnt0, 3);

        // ---- T4: full holding register blocks reads ----
        status_val = 8'h02;
        log_q.delete();
        step(60);
        reads = 0;
        polls = 0;
        foreach (log_q[k]) begin
            if (log_q[k].addr == ADDR_RX)     reads++;
            if (log_q[k].addr == ADDR_STATUS) polls++;
        end
        check("t4_no_read", reads, 0);
        check("t4_polling", polls >= 3, 1'b1);
        rx_val   = 8'h77;
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("t4_rx_cleared", rx_valid, 1'b0);
        next_nonpoll("t4_rd", r);
        check("t4_rd", {r.wr, r.addr, r.data}, {1'b0, ADDR_RX, 8'h77});
        step(1);
        check("t4_rx_data", {rx_valid, rx_data}, {1'b1, 8'h77});

        // ---- T5: sticky errors and clear priority ----
        status_val = 8'h1C;
        log_q.delete();
        next_xfer("t5_poll0", r);
        step(1);
        check("t5_err_set", err_flags, 3'b111);
        status_val = 8'h04;
        err_clr    = 1'b1;
        log_q.delete();
        next_xfer("t5_poll1", r);
        step(1);
        check("t5_err_clr_wins", err_flags, 3'b000);
        err_clr = 1'b0;
        next_xfer("t5_poll2", r);
        step(1);
        check("t5_err_parity", err_flags, 3'b001);

        // ---- T6: reset in the middle of a stretched TX write ----
        pready_wait = 3;
        tx_data0    = 8'hC3;
        tx_valid    = 2'b01;
        status_val  = 8'h01;
        c0          = tx_cnt0;
        found       = 0;
        for (int w = 0; w < 300 && found == 0; w++) begin
            step(1);
            if (apb_if.m_psel && apb_if.m_penable && apb_if.m_pwrite &&
                apb_if.m_paddr == ADDR_TX) found = 1;
        end
        if (found == 0) check("t6_access_timeout", found, 1);
        PRESETN = 1'b0;
        #1;
        check("t6_bus_idle", {apb_if.m_psel, apb_if.m_penable}, 2'b00);
        check("t6_cfg_done", cfg_done, 1'b0);
        check("t6_state_cleared", {rx_valid, err_flags}, 4'b0000);
        step(2);
        tx_valid    = 2'b00;
        status_val  = 8'h00;
        pready_wait = 0;
        log_q.delete();
        PRESETN = 1'b1;
        check("t6_no_accept", tx_cnt0, c0);
        expect_init("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
